pfd_tdc: RTL
============

PFD_TDC -- requirements
Module: pfd_tdc

Interface
REQ-001 Parameter CNT_W, default 8, width of the signed phase-error word (range ±(2^(CNT_W-1)-1)).
REQ-002 Parameter LOCK_TOL, default 1, maximum |err| in clk cycles counted as in-tolerance.
REQ-003 Parameter LOCK_CYC, default 4, consecutive in-tolerance measurements required to assert lock.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in  input  1  reference signal, asynchronous to clk.
REQ-007 fb  input  1  feedback (DCO-divided) signal, asynchronous to clk.
REQ-008 flagu  output  1  high while an in-leads measurement is open (up request).
REQ-009 flagd  output  1  high while an fb-leads measurement is open (down request).
REQ-010 err  output  CNT_W  signed phase error in clk cycles; positive = in leads.
REQ-011 err_valid  output  1  one-cycle pulse qualifying a new err value.
REQ-012 sat  output  1  one-cycle pulse, coincident with err_valid, when the measurement saturated.
REQ-013 lock  output  1  phase-lock indicator.

Function
REQ-014 in and fb SHALL each pass through a 2-flop synchronizer followed by a registered rising-edge detector; only rising edges are used.
REQ-015 Edge latency: flagu/flagd SHALL rise on the 3rd rising clk edge, counting the first edge that samples the input high.
REQ-016 FSM states SHALL be IDLE, UP, DN; reset state IDLE.
REQ-017 IDLE: in edge only -> UP, flagu=1; fb edge only -> DN, flagd=1; both edges same cycle -> stay IDLE, err=0, err_valid pulse, no flag asserted.
REQ-018 UP: fb edge -> IDLE, flagu=0, err=+d, err_valid pulse, where d = clk cycles between the detected in edge and the detected fb edge (d>=1).
REQ-019 DN: in edge -> IDLE, flagd=0, err=-d, err_valid pulse, d as in REQ-018 with roles swapped.
REQ-020 UP with fb and in edges in the same cycle: close the measurement per REQ-018, then re-enter UP with a new measurement starting that cycle; DN symmetric.
REQ-021 Repeated leading-edge in UP (in edge again) or in DN (fb edge again) SHALL be ignored; counting continues (frequency-error case).
REQ-022 Saturation: when d reaches 2^(CNT_W-1)-1 without a terminating edge, err=±max, err_valid and sat pulse, flag cleared, FSM -> IDLE; the next edge of either input opens a new measurement.
REQ-023 err SHALL hold its last value between err_valid pulses; err_valid and sat SHALL be registered outputs, asserted the cycle after the terminating edge is detected.
REQ-024 flagu and flagd SHALL never be high simultaneously.
REQ-025 Lock: a consecutive-match counter SHALL increment on each err_valid with |err|<=LOCK_TOL and clear on each err_valid with |err|>LOCK_TOL or sat=1.
REQ-026 lock SHALL assert on the cycle following the LOCK_CYC-th consecutive in-tolerance err_valid and deassert on the cycle following the first out-of-tolerance err_valid; the counter saturates at LOCK_CYC.

Reset
REQ-027 rst low SHALL immediately clear synchronizers, edge detectors, FSM (IDLE), counters, flagu, flagd, err (0), err_valid, sat and lock, without waiting for clk.
REQ-028 Reset mid-measurement SHALL discard the open measurement; no err_valid is issued for it after release.
REQ-029 After rst deasserts, an input already high SHALL NOT produce a rising edge; only a subsequent 0->1 transition counts.

Verification
REQ-030 Reset: drive rst=0 with in/fb toggling -> all outputs 0 throughout; release, hold in=fb=0 10 cycles -> outputs stay 0.
REQ-031 in leads: in rises, fb rises 5 clk later -> flagu high 5 cycles, then err=+5 with one-cycle err_valid, flagd never high.
REQ-032 fb leads: fb rises, in rises 3 clk later -> flagd high 3 cycles, err=-3 (8'hFD), err_valid one cycle.
REQ-033 Simultaneous: in and fb rise within 0.06 ns of each other, same sampling edge -> err=0, err_valid pulse, flagu=flagd=0.
REQ-034 Lock: four consecutive pairs with d=1 in-lead -> lock=1 after 4th err_valid; next pair with d=5 -> lock=0 one cycle after that err_valid.
REQ-035 Saturation/slip: in rises three times, fb held low 200 cycles -> after 127 cycles err=+127 (8'h7F), err_valid=sat=1 one cycle, flagu=0, lock=0; assert rst mid-UP in a separate run -> no err_valid after release.

Source files
------------

// File: rtl/pfd_tdc.sv
`timescale 1ns/1ps
// pfd_tdc: phase/frequency detector with time-to-digital readout and lock monitor.
// Latency: flags open 3 clk edges after an input rises; err/err_valid/sat register the cycle after the closing edge.
// Backpressure: none; err_valid is a free-running pulse and err holds until the next pulse.
module pfd_tdc #(
  parameter int CNT_W    = 8,
  parameter int LOCK_TOL = 1,
  parameter int LOCK_CYC = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in,
  input  logic                    fb,
  output logic                    flagu,
  output logic                    flagd,
  output logic signed [CNT_W-1:0] err,
  output logic                    err_valid,
  output logic                    sat,
  output logic                    lock
);

  localparam int             D_W   = CNT_W - 1;
  localparam logic [D_W-1:0] D_MAX = '1;
  localparam logic [D_W-1:0] D_ONE = D_W'(1);
  localparam int             L_W   = $clog2(LOCK_CYC + 1);

  typedef enum logic [1:0] {IDLE, UP, DN} state_t;

  // [0],[1] are the synchronizer, [2] is the edge detector history flop
  logic [2:0] in_sh, fb_sh;
  // marks when the synchronizer holds real post-reset samples
  logic [1:0] prime;
  // an input must be seen low after reset before its rising edges count
  logic       in_arm, fb_arm;
  logic       in_edge, fb_edge;

  state_t                  state, state_nxt;
  logic [D_W-1:0]          cnt, cnt_nxt;
  logic signed [CNT_W-1:0] err_nxt;
  logic                    vld_nxt, sat_nxt;

  logic [CNT_W-1:0]        err_mag;
  logic                    in_tol;
  logic [L_W-1:0]          lcnt, lcnt_nxt;

  // synchronize both inputs and arm edge detection once each is seen low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_sh  <= '0;
      fb_sh  <= '0;
      prime  <= '0;
      in_arm <= 1'b0;
      fb_arm <= 1'b0;
    end else begin
      in_sh <= {in_sh[1:0], in};
      fb_sh <= {fb_sh[1:0], fb};
      prime <= {prime[0], 1'b1};
      if (prime[1] && !in_sh[1]) in_arm <= 1'b1;
      if (prime[1] && !fb_sh[1]) fb_arm <= 1'b1;
    end
  end

  assign in_edge = in_arm & in_sh[1] & ~in_sh[2];
  assign fb_edge = fb_arm & fb_sh[1] & ~fb_sh[2];

  // measurement FSM: open on the leading edge, close on the other edge or on counter saturation
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = err;
    vld_nxt   = 1'b0;
    sat_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_edge && fb_edge) begin
          err_nxt = '0;
          vld_nxt = 1'b1;
        end else if (in_edge) begin
          state_nxt = UP;
          cnt_nxt   = D_ONE;
        end else if (fb_edge) begin
          state_nxt = DN;
          cnt_nxt   = D_ONE;
        end
      end
      UP: begin
        if (fb_edge) begin
          err_nxt = $signed({1'b0, cnt});
          vld_nxt = 1'b1;
          // a coincident in edge starts the next measurement immediately
          if (in_edge) cnt_nxt = D_ONE;
          else         state_nxt = IDLE;
        end else if (cnt == D_MAX) begin
          err_nxt   = $signed({1'b0, D_MAX});
          vld_nxt   = 1'b1;
          sat_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + D_ONE;
        end
      end
      DN: begin
        if (in_edge) begin
          err_nxt = -$signed({1'b0, cnt});
          vld_nxt = 1'b1;
          if (fb_edge) cnt_nxt = D_ONE;
          else         state_nxt = IDLE;
        end else if (cnt == D_MAX) begin
          err_nxt   = -$signed({1'b0, D_MAX});
          vld_nxt   = 1'b1;
          sat_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + D_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, interval counter and registered measurement outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      err       <= '0;
      err_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      err       <= err_nxt;
      err_valid <= vld_nxt;
      sat       <= sat_nxt;
    end
  end

  // flags decode straight from the state register, so they are mutually exclusive
  assign flagu = (state == UP);
  assign flagd = (state == DN);

  assign err_mag = err[CNT_W-1] ? $unsigned(-err) : $unsigned(err);
  assign in_tol  = (err_mag <= CNT_W'(LOCK_TOL));

  // consecutive in-tolerance counter, saturating at the lock threshold
  always_comb begin
    lcnt_nxt = lcnt;
    if (err_valid) begin
      if (in_tol && !sat) begin
        if (lcnt != L_W'(LOCK_CYC)) lcnt_nxt = lcnt + L_W'(1);
      end else begin
        lcnt_nxt = '0;
      end
    end
  end

  // lock follows the counter one cycle after the qualifying err_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lcnt <= '0;
      lock <= 1'b0;
    end else begin
      lcnt <= lcnt_nxt;
      lock <= (lcnt_nxt == L_W'(LOCK_CYC));
    end
  end

endmodule
